// File: rtl/glbl_data_mem_pkg.sv
// Shared constants for the data memory: one-hot instruction encodings, their
// bit positions, and the load-extension selector used by the alignment block.
package glbl_data_mem_pkg;

  localparam int unsigned IDX_LB  = 0;
  localparam int unsigned IDX_LH  = 1;
  localparam int unsigned IDX_LW  = 2;
  localparam int unsigned IDX_LBU = 3;
  localparam int unsigned IDX_LHU = 4;
  localparam int unsigned IDX_SB  = 5;
  localparam int unsigned IDX_SH  = 6;
  localparam int unsigned IDX_SW  = 7;

  localparam logic [63:0] inst_LB  = 64'd1 << IDX_LB;
  localparam logic [63:0] inst_LH  = 64'd1 << IDX_LH;
  localparam logic [63:0] inst_LW  = 64'd1 << IDX_LW;
  localparam logic [63:0] inst_LBU = 64'd1 << IDX_LBU;
  localparam logic [63:0] inst_LHU = 64'd1 << IDX_LHU;
  localparam logic [63:0] inst_SB  = 64'd1 << IDX_SB;
  localparam logic [63:0] inst_SH  = 64'd1 << IDX_SH;
  localparam logic [63:0] inst_SW  = 64'd1 << IDX_SW;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5
  } load_kind_e;

  // Number of bytes a store writes for a given decoded low instruction byte.
  function automatic logic [2:0] store_len(input logic [7:0] sel);
    logic [2:0] len;
    case (sel)
      inst_SB[7:0]: len = 3'd1;
      inst_SH[7:0]: len = 3'd2;
      inst_SW[7:0]: len = 3'd4;
      default:      len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/glbl_data_mem_load_align.sv
// Combinational load formatter: packs four little-endian bytes into the
// 32-bit load result with sign or zero extension.
module dmem_load_align
  import glbl_data_mem_pkg::*;
(
  input  logic [7:0]  byte0_i,
  input  logic [7:0]  byte1_i,
  input  logic [7:0]  byte2_i,
  input  logic [7:0]  byte3_i,
  input  load_kind_e  kind_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = 32'd0;
    case (kind_i)
      LD_B:    data_o = {{24{byte0_i[7]}}, byte0_i};
      LD_BU:   data_o = {24'd0, byte0_i};
      LD_H:    data_o = {{16{byte1_i[7]}}, byte1_i, byte0_i};
      LD_HU:   data_o = {16'd0, byte1_i, byte0_i};
      LD_W:    data_o = {byte3_i, byte2_i, byte1_i, byte0_i};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/glbl_data_mem.sv
// Byte-addressable little-endian data memory with combinational loads,
// clocked stores and a synchronous reset that fills byte i with i[7:0].
module glbl_data_mem
  import glbl_data_mem_pkg::*;
#(
  parameter int unsigned mem_size = 4096
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] Single_Instruction,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic [31:0] loadData_w
);

  localparam int unsigned AW = $clog2(mem_size);

  logic [7:0] DMEM [mem_size];

  logic [7:0]    sel_s;
  logic [AW-1:0] idx0_s;
  logic [AW-1:0] idx1_s;
  logic [AW-1:0] idx2_s;
  logic [AW-1:0] idx3_s;
  load_kind_e    kind_s;
  logic [2:0]    wr_len_s;
  logic [31:0]   align_data_s;
  logic          unused_s;

  assign sel_s  = Single_Instruction[7:0];
  assign idx0_s = address[AW-1:0];
  assign idx1_s = idx0_s + AW'(1);
  assign idx2_s = idx0_s + AW'(2);
  assign idx3_s = idx0_s + AW'(3);

  assign unused_s = ^{Single_Instruction[63:8], address[31:AW]};

  // Anything other than exactly one known low bit decodes to no access.
  always_comb begin
    kind_s   = LD_NONE;
    wr_len_s = 3'd0;
    if (reset) begin
      kind_s   = LD_NONE;
      wr_len_s = 3'd0;
    end else begin
      wr_len_s = store_len(sel_s);
      case (sel_s)
        inst_LB[7:0]:  kind_s = LD_B;
        inst_LBU[7:0]: kind_s = LD_BU;
        inst_LH[7:0]:  kind_s = LD_H;
        inst_LHU[7:0]: kind_s = LD_HU;
        inst_LW[7:0]:  kind_s = LD_W;
        default:       kind_s = LD_NONE;
      endcase
    end
  end

  dmem_load_align u_align (
    .byte0_i (DMEM[idx0_s]),
    .byte1_i (DMEM[idx1_s]),
    .byte2_i (DMEM[idx2_s]),
    .byte3_i (DMEM[idx3_s]),
    .kind_i  (kind_s),
    .data_o  (align_data_s)
  );

  assign loadData_w = align_data_s;

  // Reset restores the index pattern and overrides any store in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(mem_size); i++) begin
        DMEM[i] <= 8'(i);
      end
    end else begin
      if (wr_len_s != 3'd0) begin
        DMEM[idx0_s] <= storeData[7:0];
      end
      if (wr_len_s >= 3'd2) begin
        DMEM[idx1_s] <= storeData[15:8];
      end
      if (wr_len_s == 3'd4) begin
        DMEM[idx2_s] <= storeData[23:16];
        DMEM[idx3_s] <= storeData[31:24];
      end
    end
  end

endmodule

// File: tb/tb_glbl_data_mem.sv
// Directed bench for glbl_data_mem: a byte-array model checked every cycle,
// plus hand-computed expectations for the listed scenarios.
module tb_glbl_data_mem;

  localparam int MSZ = 4096;

  localparam logic [63:0] I_LB  = 64'h01;
  localparam logic [63:0] I_LH  = 64'h02;
  localparam logic [63:0] I_LW  = 64'h04;
  localparam logic [63:0] I_LBU = 64'h08;
  localparam logic [63:0] I_LHU = 64'h10;
  localparam logic [63:0] I_SB  = 64'h20;
  localparam logic [63:0] I_SH  = 64'h40;
  localparam logic [63:0] I_SW  = 64'h80;

  logic        clk;
  logic        reset;
  logic [63:0] inst;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic [31:0] ldata;

  int n_tests;
  int n_fail;

  logic [7:0] mm [MSZ];

  glbl_data_mem #(.mem_size(MSZ)) dut (
    .clk                (clk),
    .reset              (reset),
    .Single_Instruction (inst),
    .address            (addr),
    .storeData          (sdata),
    .loadData_w         (ldata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(input logic [63:0] in, input logic [31:0] a,
                                             input logic rst);
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [31:0] w;
    if (rst || $countones(in[7:0]) != 1) return 32'd0;
    b0 = mm[a % MSZ];
    b1 = mm[(a + 32'd1) % MSZ];
    w  = {mm[(a + 32'd3) % MSZ], mm[(a + 32'd2) % MSZ], b1, b0};
    if (in[0]) return 32'($signed(b0));
    if (in[3]) return 32'(b0);
    if (in[1]) return 32'($signed({b1, b0}));
    if (in[4]) return 32'({b1, b0});
    if (in[2]) return w;
    return 32'd0;
  endfunction

  // Model state update at the clock edge.
  always @(posedge clk) begin
    int n;
    if (reset) begin
      for (int i = 0; i < MSZ; i++) mm[i] = 8'(i);
    end else if ($countones(inst[7:0]) == 1) begin
      n = inst[5] ? 1 : (inst[6] ? 2 : (inst[7] ? 4 : 0));
      for (int k = 0; k < n; k++) mm[(addr + 32'(k)) % MSZ] = sdata[8*k +: 8];
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] exp;
    exp = model_load(inst, addr, reset);
    n_tests++;
    if (ldata !== exp) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t inst=%h addr=%h got=%h exp=%h",
               $time, inst, addr, ldata, exp);
    end
  end

  task automatic drive(input logic rst, input logic [63:0] in, input logic [31:0] a,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    reset = rst;
    inst  = in;
    addr  = a;
    sdata = d;
  endtask

  task automatic check(input string name, input logic [31:0] exp);
    @(negedge clk);
    #1;
    n_tests++;
    if (ldata !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, ldata, exp);
    end
  endtask

  task automatic ld(input string name, input logic [63:0] in, input logic [31:0] a,
                    input logic [31:0] exp);
    drive(1'b0, in, a, 32'h0);
    check(name, exp);
  endtask

  task automatic st(input string name, input logic [63:0] in, input logic [31:0] a,
                    input logic [31:0] d);
    drive(1'b0, in, a, d);
    check(name, 32'h0);
  endtask

  task automatic rst_cycle(input string name, input logic [63:0] in, input logic [31:0] a,
                           input logic [31:0] d);
    drive(1'b1, in, a, d);
    check(name, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    inst    = 64'h0;
    addr    = 32'h0;
    sdata   = 32'h0;
    rst_cycle("reset_out0", I_LW, 32'h8, 32'h0);
    rst_cycle("reset_out1", I_LB, 32'h4, 32'h0);

    ld("lb_4",     I_LB,  32'h4,  32'h00000004);
    ld("lh_18",    I_LH,  32'h18, 32'h00001918);
    ld("lw_8",     I_LW,  32'h8,  32'h0B0A0908);
    ld("lb_80",    I_LB,  32'h80, 32'hFFFFFF80);
    ld("lbu_80",   I_LBU, 32'h80, 32'h00000080);

    st("sb_4",     I_SB,  32'h4,  32'h000000AA);
    ld("lbu_4",    I_LBU, 32'h4,  32'h000000AA);
    ld("lb_4s",    I_LB,  32'h4,  32'hFFFFFFAA);
    ld("lw_4a",    I_LW,  32'h4,  32'h070605AA);

    rst_cycle("reset_a", 64'h0, 32'h0, 32'h0);
    st("sh_6",     I_SH,  32'h6,  32'h0000BBCC);
    ld("lhu_6",    I_LHU, 32'h6,  32'h0000BBCC);
    ld("lh_6",     I_LH,  32'h6,  32'hFFFFBBCC);
    ld("lw_4b",    I_LW,  32'h4,  32'hBBCC0504);

    st("sw_8",     I_SW,  32'h8,  32'hDEADBEEF);
    ld("lw_8b",    I_LW,  32'h8,  32'hDEADBEEF);
    ld("lhu_a",    I_LHU, 32'hA,  32'h0000DEAD);
    ld("lb_b",     I_LB,  32'hB,  32'hFFFFFFDE);

    rst_cycle("reset_b", 64'h0, 32'h0, 32'h0);
    ld("lw_ffe",   I_LW,  32'hFFE,  32'h0100FFFE);
    ld("lw_1004",  I_LW,  32'h1004, 32'h07060504);
    st("sh_fff",   I_SH,  32'hFFF,  32'h00001234);
    ld("lbu_fff",  I_LBU, 32'hFFF,  32'h00000034);
    ld("lbu_0",    I_LBU, 32'h0,    32'h00000012);

    st("illegal",  64'h21, 32'h10, 32'hFFFFFFFF);
    ld("lw_10",    I_LW,  32'h10, 32'h13121110);
    st("no_inst",  64'h0,  32'h10, 32'hFFFFFFFF);
    ld("lw_10b",   I_LW,  32'h10, 32'h13121110);
    ld("hi_bits",  64'h100 | I_LB, 32'h4, 32'h00000004);
    st("hi_sw",    64'hF00 | I_SW, 32'h14, 32'hA1B2C3D4);
    ld("lw_14",    I_LW,  32'h14, 32'hA1B2C3D4);

    st("sw_0",     I_SW,  32'h0,  32'hFFFFFFFF);
    ld("lw_0ff",   I_LW,  32'h0,  32'hFFFFFFFF);
    rst_cycle("reset_c", I_SW, 32'h20, 32'h00000000);
    ld("lw_0rst",  I_LW,  32'h0,  32'h03020100);
    ld("lw_20",    I_LW,  32'h20, 32'h23222120);

    drive(1'b0, 64'h0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glbl_data_mem.md
Name: glbl_data_mem

Overview:
Byte-addressable, little-endian data memory for the riscv32i core's load/store stage.
- Decoded one-hot load/store instruction vector selects the access type.
- Loads return sign- or zero-extended data combinationally.
- Stores commit on the rising clock edge.
- The whole array is resettable to a known pattern so loads are deterministic before any store.

Parameters:
mem_size, 4096, number of bytes in the array; power of two.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
Single_Instruction  in  64  one-hot decoded instruction vector; only bits [7:0] are used
address  in  32  byte address
storeData  in  32  store data; low byte/half/word is used per access type
loadData_w  out  32  load result, combinational

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset).
- Instruction bits:
  - 0 = LB, 1 = LH, 2 = LW, 3 = LBU, 4 = LHU
  - 5 = SB, 6 = SH, 7 = SW
  - bits [63:8] are ignored.
- Effective byte index = address[log2(mem_size)-1:0]. Upper address bits are ignored (wrap-around).
- Multi-byte accesses use indices a, a+1, a+2, a+3, each modulo mem_size. Misaligned accesses are legal, with no trap. Little-endian: byte a is the LSB.
- Reset: on a posedge with reset=1, byte i of the array is loaded with i[7:0]. Stores are suppressed that cycle. loadData_w = 0 while reset=1.
- Loads are combinational, zero latency. loadData_w follows address/instruction in the same cycle:
  - LB = sign-extended byte a
  - LBU = zero-extended byte a
  - LH = sign-extended {a+1, a}
  - LHU = zero-extended {a+1, a}
  - LW = {a+3, a+2, a+1, a}
- Stores are synchronous. On posedge with reset=0:
  - SB writes storeData[7:0] to a.
  - SH writes [7:0] to a and [15:8] to a+1.
  - SW writes 4 bytes.
  - Written data is visible to a load in the following cycle.
- If none of bits [7:0] are set, or more than one is set: no write, and loadData_w = 0.
- During a store cycle loadData_w = 0.
- Array contents persist until overwritten or reset. Reset mid-operation discards any store in that cycle and restores the full pattern.
- The array is named DMEM: a mem_size x 8 register array reachable hierarchically for memory dumps.

Decomposition:
- Shared package params.vh holds:
  - 64-bit localparams inst_LB = 1<<0, inst_LH = 1<<1, inst_LW = 1<<2, inst_LBU = 1<<3, inst_LHU = 1<<4, inst_SB = 1<<5, inst_SH = 1<<6, inst_SW = 1<<7
  - matching bit-index constants.
- One natural sub-module: dmem_load_align, a purely combinational block.
  - Inputs: four fetched bytes plus access type.
  - Output: the extended 32-bit result.
- Storage, reset and write-enable logic live in the top module.

Test Plan:
- Reset released, no store:
  - LB @0x4 -> 0x00000004
  - LH @0x18 -> 0x00001918
  - LW @0x8 -> 0x0B0A0908
  - LB @0x80 -> 0xFFFFFF80
  - LBU @0x80 -> 0x00000080
- SB @0x4 data 0xAA:
  - then LBU @0x4 -> 0x000000AA
  - LB @0x4 -> 0xFFFFFFAA
  - LW @0x4 -> 0x070605AA
- SH @0x6 data 0x0000BBCC:
  - then LHU @0x6 -> 0x0000BBCC
  - LH @0x6 -> 0xFFFFBBCC
  - LW @0x4 -> 0xBBCC0504 after a fresh reset
- SW @0x8 data 0xDEADBEEF:
  - then LW @0x8 -> 0xDEADBEEF
  - LHU @0xA -> 0x0000DEAD
  - LB @0xB -> 0xFFFFFFDE
- Wrap and misalignment:
  - LW @0xFFE -> 0x0100FFFE
  - LW @0x1004 -> 0x07060504 (upper address bits ignored)
  - SH @0xFFF data 0x1234, then LBU @0xFFF -> 0x34 and LBU @0x0 -> 0x12
- Illegal instruction and reset:
  - Single_Instruction = 0x21 (LB|SB) -> loadData_w = 0 and memory unchanged.
  - SW @0x0 data 0xFFFFFFFF, then reset for one cycle -> LW @0x0 -> 0x03020100.
